// File: rtl/l0_line_supplier.sv
// l0_line_supplier: holds the fetch PC and a small FIFO-replaced L0 line buffer,
// presenting hits or miss announcements to fetch and refilling misses from L1I.
module l0_line_supplier #(
   parameter int          CACHE_LINE_WIDTH   = 64,
   parameter int          SUPER_SCALAR_WIDTH = 4,
   parameter int          L0_ENTRIES         = 4,
   parameter logic [63:0] RESET_PC           = 64'h0
) (
   input  logic                          clk_in,
   input  logic                          rst_N_in,
   input  logic                          flush_in,
   input  logic [63:0]                   flush_pc_in,
   input  logic                          bp_taken_in,
   input  logic [63:0]                   bp_target_in,
   input  logic                          fetch_ready_in,
   input  logic                          l0_inv_in,
   output logic [63:0]                   pred_pc,
   output logic                          pc_valid,
   output logic                          bp_l0_valid,
   output logic [CACHE_LINE_WIDTH*8-1:0] l0_cacheline,
   output logic                          l1i_req_valid_out,
   output logic [63:0]                   l1i_req_addr_out,
   input  logic                          l1i_req_ready_in,
   input  logic                          l1i_fill_valid_in,
   input  logic [CACHE_LINE_WIDTH*8-1:0] l1i_fill_line_in
);
   localparam int OB = $clog2(CACHE_LINE_WIDTH);
   localparam int LW = CACHE_LINE_WIDTH * 8;
   localparam int RB = $clog2(L0_ENTRIES);
   localparam logic [63:0] GROUP_BYTES = 64'(4 * SUPER_SCALAR_WIDTH);

   typedef enum logic [1:0] {RUN, MISS_REQ, MISS_WAIT, DRAIN} state_t;

   state_t                r_state, w_state_nxt;
   logic [63:0]           r_pc, r_pend_pc, w_pc_nxt, w_seq, w_nxt, w_off;
   logic [63-OB:0]        r_miss_tag;
   logic [RB-1:0]         r_rptr, w_hit_idx;
   logic [L0_ENTRIES-1:0] r_vld;
   logic [63-OB:0]        r_tag  [L0_ENTRIES];
   logic [LW-1:0]         r_line [L0_ENTRIES];
   logic                  w_hit, w_present, w_miss, w_install;

   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = 0; i < L0_ENTRIES; i++)
         if (r_vld[i] && r_tag[i] == r_pc[63:OB]) begin
            w_hit     = 1'b1;
            w_hit_idx = RB'(i);
         end
   end

   // Groups crossing the line end restart at the next line; fetch pads with NOPs.
   assign w_off = 64'(r_pc[OB-1:0]) + GROUP_BYTES;
   assign w_seq = (w_off >= 64'(CACHE_LINE_WIDTH)) ? {r_pc[63:OB] + (64-OB)'(1), {OB{1'b0}}}
                                                    : r_pc + GROUP_BYTES;
   assign w_nxt = bp_taken_in ? bp_target_in : w_seq;

   assign l1i_req_valid_out = (r_state == MISS_REQ);
   assign l1i_req_addr_out  = {r_miss_tag, {OB{1'b0}}};

   always_ff @(posedge clk_in or negedge rst_N_in)
      if (!rst_N_in) r_state <= RUN;
      else           r_state <= w_state_nxt;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = flush_in ? flush_pc_in : r_pc;
      w_present   = 1'b0;
      w_miss      = 1'b0;
      w_install   = 1'b0;
      case (r_state)
         RUN: begin
            w_present   = !flush_in && fetch_ready_in;
            w_miss      = w_present && !w_hit;
            w_pc_nxt    = flush_in ? flush_pc_in : (w_present && w_hit) ? w_nxt : r_pc;
            w_state_nxt = w_miss ? MISS_REQ : RUN;
         end
         MISS_REQ:
            w_state_nxt = l1i_req_ready_in ? (flush_in ? DRAIN : MISS_WAIT)
                                           : (flush_in ? RUN : MISS_REQ);
         MISS_WAIT: begin
            w_install   = l1i_fill_valid_in;
            w_pc_nxt    = flush_in ? flush_pc_in : l1i_fill_valid_in ? r_pend_pc : r_pc;
            w_state_nxt = l1i_fill_valid_in ? RUN : flush_in ? DRAIN : MISS_WAIT;
         end
         DRAIN: begin
            w_install   = l1i_fill_valid_in;
            w_state_nxt = l1i_fill_valid_in ? RUN : DRAIN;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_N_in)
      if (!rst_N_in) begin
         r_pc         <= RESET_PC;
         r_pend_pc    <= '0;
         r_miss_tag   <= '0;
         r_rptr       <= '0;
         r_vld        <= '0;
         pred_pc      <= '0;
         pc_valid     <= 1'b0;
         bp_l0_valid  <= 1'b0;
         l0_cacheline <= '0;
      end else begin
         r_pc        <= w_pc_nxt;
         pc_valid    <= w_present;
         bp_l0_valid <= w_present && w_hit;
         if (w_present) pred_pc <= r_pc;
         if (w_present && w_hit) l0_cacheline <= r_line[w_hit_idx];
         if (w_miss) begin
            r_miss_tag <= r_pc[63:OB];
            r_pend_pc  <= w_nxt;
         end
         if (l0_inv_in) r_vld <= '0;
         if (w_install) begin
            r_vld[r_rptr] <= 1'b1;
            r_rptr        <= r_rptr + RB'(1);
         end
      end

   always_ff @(posedge clk_in)
      if (w_install) begin
         r_tag[r_rptr]  <= r_miss_tag;
         r_line[r_rptr] <= l1i_fill_line_in;
      end
endmodule
